// File: rtl/as_gpio_seq_checker_if.sv
// GPIO write strobe bus as driven by the core's result port.
// The master drives a one-cycle cs_i pulse per write; the slave samples on the rising clock edge.
interface as_gpio_seq_checker_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              cs_i;
    logic [ADDR_W-1:0] gpioAddr_i;
    logic [DATA_W-1:0] gpio_i;

    modport master (output cs_i, output gpioAddr_i, output gpio_i);
    modport slave  (input  cs_i, input  gpioAddr_i, input  gpio_i);
endinterface

// File: rtl/as_gpio_seq_checker.sv
// Compares GPIO result writes against a runtime-loaded expected sequence.
// It also supervises a progress timeout and reports sticky pass/fail with error diagnostics.
module as_gpio_seq_checker #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int CHK_ADDR = 4,
    parameter int MAX_SEQ  = 16,
    parameter int TO_W     = 16,
    localparam int IDX_W   = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1,
    localparam int CNT_W   = $clog2(MAX_SEQ) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    as_gpio_seq_checker_if.slave   bus,
    input  logic                   exp_we_i,
    input  logic [IDX_W-1:0]       exp_idx_i,
    input  logic [DATA_W-1:0]      exp_data_i,
    input  logic [CNT_W-1:0]       seq_len_i,
    input  logic                   strict_i,
    input  logic [TO_W-1:0]        to_limit_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   pass_o,
    output logic                   fail_o,
    output logic [2:0]             err_code_o,
    output logic [IDX_W-1:0]       err_idx_o,
    output logic [DATA_W-1:0]      err_data_o,
    output logic [CNT_W-1:0]       match_cnt_o,
    output logic [1:0]             dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PASS = 2'd2, S_FAIL = 2'd3} state_t;

    localparam logic [ADDR_W-1:0] CHK     = ADDR_W'(CHK_ADDR);
    localparam logic [CNT_W-1:0]  MAX_LEN = CNT_W'(MAX_SEQ);

    localparam logic [2:0] E_NONE = 3'd0, E_DATA = 3'd1, E_ADDR = 3'd2, E_TMO = 3'd3, E_OVR = 3'd4;

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [CNT_W-1:0]  match_n;
    logic [TO_W-1:0]   timer, timer_n, timer_inc;
    logic [CNT_W-1:0]  len_q, len_n, len_clamped;
    logic              strict_q, strict_n;
    logic [TO_W-1:0]   limit_q, limit_n;
    logic              pass_n, fail_n;
    logic [2:0]        code_n;
    logic [IDX_W-1:0]  eidx_n;
    logic [DATA_W-1:0] edata_n;
    logic              chk_hit;

    logic [DATA_W-1:0] mem [MAX_SEQ];

    // The sequence under check is frozen while running.
    always_ff @(posedge clk_i) begin
        if (exp_we_i && state != S_RUN) begin
            mem[exp_idx_i] <= exp_data_i;
        end
    end

    assign len_clamped = (seq_len_i > MAX_LEN) ? MAX_LEN : seq_len_i;
    assign timer_inc   = (timer == '1) ? timer : timer + TO_W'(1);
    assign chk_hit     = bus.cs_i && (bus.gpioAddr_i == CHK);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            idx         <= '0;
            match_cnt_o <= '0;
            timer       <= '0;
            len_q       <= '0;
            strict_q    <= 1'b0;
            limit_q     <= '0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            err_code_o  <= E_NONE;
            err_idx_o   <= '0;
            err_data_o  <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            match_cnt_o <= match_n;
            timer       <= timer_n;
            len_q       <= len_n;
            strict_q    <= strict_n;
            limit_q     <= limit_n;
            pass_o      <= pass_n;
            fail_o      <= fail_n;
            err_code_o  <= code_n;
            err_idx_o   <= eidx_n;
            err_data_o  <= edata_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        match_n  = match_cnt_o;
        timer_n  = timer;
        len_n    = len_q;
        strict_n = strict_q;
        limit_n  = limit_q;
        pass_n   = pass_o;
        fail_n   = fail_o;
        code_n   = err_code_o;
        eidx_n   = err_idx_o;
        edata_n  = err_data_o;

        // Start outranks any write in the same cycle and restarts from any state.
        if (start_i) begin
            len_n    = len_clamped;
            strict_n = strict_i;
            limit_n  = to_limit_i;
            idx_n    = '0;
            match_n  = '0;
            timer_n  = '0;
            pass_n   = 1'b0;
            fail_n   = 1'b0;
            code_n   = E_NONE;
            eidx_n   = '0;
            edata_n  = '0;
            if (len_clamped == '0) begin
                state_n = S_PASS;
                pass_n  = 1'b1;
            end else begin
                state_n = S_RUN;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (chk_hit && bus.gpio_i == mem[idx]) begin
                        idx_n   = idx + IDX_W'(1);
                        match_n = match_cnt_o + CNT_W'(1);
                        timer_n = '0;
                        if (CNT_W'(idx) + CNT_W'(1) == len_q) begin
                            state_n = S_PASS;
                            pass_n  = 1'b1;
                        end
                    end else if (chk_hit) begin
                        state_n = S_FAIL;
                        fail_n  = 1'b1;
                        code_n  = E_DATA;
                        eidx_n  = idx;
                        edata_n = bus.gpio_i;
                    end else if (bus.cs_i && strict_q) begin
                        state_n = S_FAIL;
                        fail_n  = 1'b1;
                        code_n  = E_ADDR;
                        eidx_n  = idx;
                        edata_n = bus.gpio_i;
                    end else begin
                        timer_n = timer_inc;
                        if (limit_q != '0 && timer_inc >= limit_q) begin
                            state_n = S_FAIL;
                            fail_n  = 1'b1;
                            code_n  = E_TMO;
                            eidx_n  = idx;
                            edata_n = '0;
                        end
                    end
                end
                S_PASS: begin
                    if (chk_hit) begin
                        state_n = S_FAIL;
                        pass_n  = 1'b0;
                        fail_n  = 1'b1;
                        code_n  = E_OVR;
                        eidx_n  = (len_q == '0) ? '0 : IDX_W'(len_q - CNT_W'(1));
                        edata_n = bus.gpio_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o    = (state == S_RUN);
    assign dbg_state = state;
endmodule
